// File: rtl/brick_hit_tracker_if.sv
// Bundle between the ball/paddle controller (master) and the brick hit tracker (slave).
// Carries the per-tick brick overlap in and the destroyed-brick state, hit report and score out.
interface brick_hit_tracker_if #(
    parameter int NUM_BRICKS = 140,
    parameter int SCORE_W    = 16
);
    logic                  start;
    logic                  ball_tick;
    logic [NUM_BRICKS-1:0] brick;
    logic [NUM_BRICKS-1:0] flag;
    logic                  hit;
    logic [3:0]            hit_row;
    logic [3:0]            hit_col;
    logic [7:0]            bricks_left;
    logic [SCORE_W-1:0]    score;
    logic                  level_clear;

    modport master (
        output start,
        output ball_tick,
        output brick,
        input  flag,
        input  hit,
        input  hit_row,
        input  hit_col,
        input  bricks_left,
        input  score,
        input  level_clear
    );

    modport slave (
        input  start,
        input  ball_tick,
        input  brick,
        output flag,
        output hit,
        output hit_row,
        output hit_col,
        output bricks_left,
        output score,
        output level_clear
    );
endinterface

// File: rtl/brick_hit_tracker.sv
// Destroyed-brick bookkeeping: destroys at most one brick per ball tick (lowest index wins),
// reports its row/column, tracks score and bricks remaining, and flags level clear.
module brick_hit_tracker #(
    parameter int NUM_BRICKS     = 140,
    parameter int NUM_COLS       = 14,
    parameter int COOLDOWN_TICKS = 2,
    parameter int SCORE_W        = 16,
    parameter int POINTS         = 1
) (
    input  logic               clk,
    input  logic               rst,
    brick_hit_tracker_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_BRICKS);
    localparam int CD_W  = $clog2(COOLDOWN_TICKS + 1);

    localparam logic [IDX_W-1:0]   COLS        = IDX_W'(NUM_COLS);
    localparam logic [7:0]         BRICKS_INIT = 8'(NUM_BRICKS);
    localparam logic [CD_W-1:0]    CD_INIT     = CD_W'(COOLDOWN_TICKS);
    localparam logic [SCORE_W:0]   POINTS_EXT  = (SCORE_W + 1)'(POINTS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_CLEAR
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_BRICKS-1:0] flag_q, flag_d;
    logic                  hit_q, hit_d;
    logic [3:0]            hit_row_q, hit_row_d;
    logic [3:0]            hit_col_q, hit_col_d;
    logic [7:0]            bricks_left_q, bricks_left_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [CD_W-1:0]       cooldown_q, cooldown_d;

    logic [NUM_BRICKS-1:0] live_brick;
    logic [NUM_BRICKS-1:0] hit_onehot;
    logic [IDX_W-1:0]      hit_idx;
    logic [3:0]            idx_row;
    logic [3:0]            idx_col;
    logic                  any_live;
    logic                  hit_qual;
    logic [SCORE_W:0]      score_sum;
    logic [SCORE_W-1:0]    score_sat;

    // Already-destroyed bricks never count again, even if the map upstream is ungated.
    for (genvar gi = 0; gi < NUM_BRICKS; gi++) begin : g_live
        assign live_brick[gi] = bus.brick[gi] & ~flag_q[gi];
    end

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_BRICKS - 1; i >= 0; i--) begin
            if (live_brick[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign any_live   = |live_brick;
    assign hit_onehot = NUM_BRICKS'(1) << hit_idx;
    assign idx_row    = 4'(hit_idx / COLS);
    assign idx_col    = 4'(hit_idx % COLS);

    assign score_sum = {1'b0, score_q} + POINTS_EXT;
    assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    assign hit_qual = (state_q == ST_PLAY) && bus.ball_tick && (cooldown_q == '0)
                      && any_live && !bus.start;

    always_comb begin
        state_d       = state_q;
        flag_d        = flag_q;
        hit_d         = 1'b0;
        hit_row_d     = hit_row_q;
        hit_col_d     = hit_col_q;
        bricks_left_d = bricks_left_q;
        score_d       = score_q;
        cooldown_d    = cooldown_q;

        // Cooldown counts ball ticks, not clock cycles.
        if (bus.ball_tick && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                end
            end
            ST_PLAY: begin
                if (bus.start) begin
                    score_d = '0;
                end else if (hit_qual) begin
                    flag_d     = flag_q | hit_onehot;
                    hit_d      = 1'b1;
                    hit_row_d  = idx_row;
                    hit_col_d  = idx_col;
                    score_d    = score_sat;
                    cooldown_d = CD_INIT;
                    if (bricks_left_q != '0) begin
                        bricks_left_d = bricks_left_q - 1'b1;
                    end
                    if (bricks_left_q <= 8'd1) begin
                        state_d = ST_CLEAR;
                    end
                end else if (bricks_left_q == '0) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Score carries over into the next level.
                if (bus.start) begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.start) begin
            state_d       = ST_PLAY;
            flag_d        = '0;
            hit_d         = 1'b0;
            hit_row_d     = '0;
            hit_col_d     = '0;
            bricks_left_d = BRICKS_INIT;
            cooldown_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            flag_q        <= '0;
            hit_q         <= 1'b0;
            hit_row_q     <= '0;
            hit_col_q     <= '0;
            bricks_left_q <= BRICKS_INIT;
            score_q       <= '0;
            cooldown_q    <= '0;
        end else begin
            state_q       <= state_d;
            flag_q        <= flag_d;
            hit_q         <= hit_d;
            hit_row_q     <= hit_row_d;
            hit_col_q     <= hit_col_d;
            bricks_left_q <= bricks_left_d;
            score_q       <= score_d;
            cooldown_q    <= cooldown_d;
        end
    end

    assign bus.flag        = flag_q;
    assign bus.hit         = hit_q;
    assign bus.hit_row     = hit_row_q;
    assign bus.hit_col     = hit_col_q;
    assign bus.bricks_left = bricks_left_q;
    assign bus.score       = score_q;
    assign bus.level_clear = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_brick_hit_tracker.sv
// Directed bench for brick_hit_tracker: vector table for single-tick behaviour plus
// hand-written sequences for reset, start collisions and a full level clear.
module tb_brick_hit_tracker;
    localparam int NB = 140;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    brick_hit_tracker_if #(.NUM_BRICKS(NB), .SCORE_W(16)) bus ();

    brick_hit_tracker #(
        .NUM_BRICKS(NB), .NUM_COLS(14), .COOLDOWN_TICKS(2), .SCORE_W(16), .POINTS(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic           start;
        logic           tick;
        logic [NB-1:0]  brick;
        logic           e_hit;
        logic [3:0]     e_row;
        logic [3:0]     e_col;
        logic [7:0]     e_left;
        logic [15:0]    e_score;
        logic           e_lc;
        int             e_ones;
        int             chk_idx;
        logic           chk_val;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [NB-1:0] b(input int i);
        logic [NB-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic add(input logic s, input logic t, input logic [NB-1:0] br,
                       input logic h, input int row, input int col, input int left,
                       input int sc, input logic lc, input int ones,
                       input int ci, input logic cv);
        vec_t v;
        v.start = s; v.tick = t; v.brick = br; v.e_hit = h;
        v.e_row = 4'(row); v.e_col = 4'(col); v.e_left = 8'(left);
        v.e_score = 16'(sc); v.e_lc = lc; v.e_ones = ones; v.chk_idx = ci; v.chk_val = cv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic s, input logic t, input logic [NB-1:0] br);
        @(negedge clk);
        bus.start     = s;
        bus.ball_tick = t;
        bus.brick     = br;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.ball_tick = 1'b0;
        bus.brick     = '0;
    endtask

    task automatic chk_all(input string p, input logic h, input int row, input int col,
                           input int left, input int sc, input logic lc, input int ones);
        chk({p, "_hit"},   bus.hit, h);
        chk({p, "_row"},   bus.hit_row, row);
        chk({p, "_col"},   bus.hit_col, col);
        chk({p, "_left"},  bus.bricks_left, left);
        chk({p, "_score"}, bus.score, sc);
        chk({p, "_clear"}, bus.level_clear, lc);
        chk({p, "_flags"}, $countones(bus.flag), ones);
    endtask

    initial begin
        logic [NB-1:0] all_ones;
        all_ones = '1;
        bus.start = 1'b0;
        bus.ball_tick = 1'b0;
        bus.brick = '0;

        //            st tk brick         hit row col left sc lc ones chk val
        add(1, 0, '0,                 0, 0, 0,  140, 0, 0, 0, -1, 0);
        add(0, 1, b(0),               1, 0, 0,  139, 1, 0, 1,  0, 1);
        add(0, 0, '0,                 0, 0, 0,  139, 1, 0, 1, -1, 0);
        add(0, 1, '0,                 0, 0, 0,  139, 1, 0, 1, -1, 0);
        add(0, 1, '0,                 0, 0, 0,  139, 1, 0, 1, -1, 0);
        add(0, 1, b(15) | b(29),      1, 1, 1,  138, 2, 0, 2, 15, 1);
        add(0, 0, '0,                 0, 1, 1,  138, 2, 0, 2, 29, 0);
        add(0, 1, b(20),              0, 1, 1,  138, 2, 0, 2, 20, 0);
        add(0, 1, b(20),              0, 1, 1,  138, 2, 0, 2, 20, 0);
        add(0, 1, b(20),              1, 1, 6,  137, 3, 0, 3, 20, 1);
        add(0, 1, '0,                 0, 1, 6,  137, 3, 0, 3, -1, 0);
        add(0, 1, '0,                 0, 1, 6,  137, 3, 0, 3, -1, 0);
        add(0, 1, b(20),              0, 1, 6,  137, 3, 0, 3, -1, 0);
        add(0, 1, '0,                 0, 1, 6,  137, 3, 0, 3, -1, 0);
        add(0, 1, b(20) | b(139),     1, 9, 13, 136, 4, 0, 4, 139, 1);

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 140, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores ball ticks.
        drive(0, 1, b(3));
        chk_all("idle_tick", 0, 0, 0, 140, 0, 0, 0);
        drive(0, 1, '0);
        chk_all("idle_zero", 0, 0, 0, 140, 0, 0, 0);

        foreach (vecs[i]) begin
            string p;
            p = $sformatf("v%0d", i);
            drive(vecs[i].start, vecs[i].tick, vecs[i].brick);
            chk_all(p, vecs[i].e_hit, vecs[i].e_row, vecs[i].e_col, vecs[i].e_left,
                    vecs[i].e_score, vecs[i].e_lc, vecs[i].e_ones);
            if (vecs[i].chk_idx >= 0)
                chk({p, "_flagbit"}, bus.flag[vecs[i].chk_idx], vecs[i].chk_val);
            $display("vector %0d: hit=%0d row=%0d col=%0d left=%0d score=%0d", i,
                     bus.hit, bus.hit_row, bus.hit_col, bus.bricks_left, bus.score);
        end

        // start collides with a tick in PLAY: no hit, score cleared.
        drive(1, 1, b(5));
        chk_all("start_tick", 0, 0, 0, 140, 0, 0, 0);
        chk("start_tick_flag5", bus.flag[5], 0);
        drive(0, 1, b(5));
        chk_all("after_start", 1, 0, 5, 139, 1, 0, 1);
        $display("start collision: hit=%0d col=%0d", bus.hit, bus.hit_col);

        // Asynchronous reset mid-play, asserted and checked between clock edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 140, 0, 0, 0);
        $display("async reset: left=%0d score=%0d", bus.bricks_left, bus.score);
        @(negedge clk);
        rst = 1'b0;

        // Full level: every tick presents all bricks, the lowest live one goes.
        drive(1, 0, '0);
        chk_all("lvl_start", 0, 0, 0, 140, 0, 0, 0);
        for (int i = 0; i < NB; i++) begin
            string p;
            p = $sformatf("lvl%0d", i);
            drive(0, 1, all_ones);
            chk({p, "_hit"},   bus.hit, 1);
            chk({p, "_row"},   bus.hit_row, i / 14);
            chk({p, "_col"},   bus.hit_col, i % 14);
            chk({p, "_left"},  bus.bricks_left, 139 - i);
            chk({p, "_score"}, bus.score, i + 1);
            chk({p, "_clear"}, bus.level_clear, (i == NB - 1) ? 1 : 0);
            $display("level hit %0d: row=%0d col=%0d left=%0d score=%0d clear=%0d", i,
                     bus.hit_row, bus.hit_col, bus.bricks_left, bus.score, bus.level_clear);
            drive(0, 1, '0);
            drive(0, 1, '0);
        end
        chk("lvl_all_flags", $countones(bus.flag), NB);

        drive(0, 1, all_ones);
        chk_all("clear_tick", 0, 9, 13, 0, 140, 1, 140);
        drive(1, 0, '0);
        chk_all("next_level", 0, 0, 0, 140, 140, 0, 0);
        drive(0, 1, b(7));
        chk_all("next_hit", 1, 0, 7, 139, 141, 0, 1);
        $display("next level hit: col=%0d score=%0d", bus.hit_col, bus.score);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
